// File: rtl/result_byte_serializer.sv
// Buffers 32-bit result words in a small FIFO and shows each one on an 8-bit port, MSB byte first, each byte held HOLD_CYCLES cycles.
// Optional build macro RESULT_CHANGE_ONLY_EN: discard a valid word equal to the last accepted word.
module result_byte_serializer #(
   parameter int HOLD_CYCLES = 4,
   parameter int DEPTH       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] result_in,
   input  logic        result_valid,
   output logic        result_ready,
   output logic [7:0]  out,
   output logic [1:0]  out_idx,
   output logic        out_valid,
   output logic        frame_start,
   output logic        overflow
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       word_q, word_d;
   logic [7:0]        out_q, out_d;
   logic              valid_q, valid_d;
   logic              fs_q, fs_d;
   logic              ovf_q, ovf_d;

   logic              full, empty, dup, push, pop;
   logic [31:0]       head;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

`ifdef RESULT_CHANGE_ONLY_EN
   logic [31:0] last_q, last_d;
   logic        seen_q, seen_d;

   assign dup = seen_q && (result_in == last_q);

   always_comb begin
      last_d = last_q;
      seen_d = seen_q;
      if (push) begin
         last_d = result_in;
         seen_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) seen_q <= 1'b0;
      else     seen_q <= seen_d;
      last_q <= last_d;
   end
`else
   assign dup = 1'b0;
`endif

   // Duplicates are discarded before the full check, so they never count as drops.
   assign push = result_valid && !full && !dup;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) begin
         mem_d[wr_ptr_q] = result_in;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (result_valid && full && !dup) ovf_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      word_d  = word_q;
      out_d   = out_q;
      valid_d = valid_q;
      fs_d    = 1'b0;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (!empty) begin
               pop     = 1'b1;
               word_d  = head;
               out_d   = head[31:24];
               idx_d   = 2'd0;
               hold_d  = '0;
               valid_d = 1'b1;
               fs_d    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (hold_q != HOLD_LAST) begin
               hold_d = hold_q + 1'b1;
            end else begin
               hold_d = '0;
               if (idx_q != 2'd3) begin
                  idx_d = idx_q + 2'd1;
                  out_d = byte_sel(word_q, idx_q + 2'd1);
               end else if (!empty) begin
                  // Back-to-back frame: the next word follows with no gap cycle.
                  pop    = 1'b1;
                  word_d = head;
                  out_d  = head[31:24];
                  idx_d  = 2'd0;
                  fs_d   = 1'b1;
               end else begin
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         hold_q   <= '0;
         idx_q    <= 2'd0;
         out_q    <= 8'd0;
         valid_q  <= 1'b0;
         fs_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         hold_q   <= hold_d;
         idx_q    <= idx_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         fs_q     <= fs_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q  <= mem_d;
      word_q <= word_d;
   end

   assign result_ready = !full;
   assign out          = out_q;
   assign out_idx      = idx_q;
   assign out_valid    = valid_q;
   assign frame_start  = fs_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_result_byte_serializer.sv
// Bench for result_byte_serializer: a HOLD_CYCLES=4 instance checked every cycle against a frame-level model,
// plus a HOLD_CYCLES=1 instance checked with a directed sequence.
module tb_result_byte_serializer;

   localparam int H  = 4;
   localparam int D  = 4;
   localparam int FL = 4 * H;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] d0, d1;
   logic        v0, v1;
   logic        ready0, ready1;
   logic [7:0]  out0, out1;
   logic [1:0]  idx0, idx1;
   logic        valid0, valid1, fs0, fs1, ovf0, ovf1;

   int checks = 0;
   int errors = 0;
   int frames = 0;

   // Reference model: pending words, current frame and elapsed cycles within it.
   logic [31:0] mq[$];
   bit          m_active;
   logic [31:0] m_word;
   int          m_k;
   logic [7:0]  m_out;
   logic [1:0]  m_idx;
   bit          m_fs, m_ovf, m_seen;
   logic [31:0] m_last;

   always #5 clk = ~clk;

   result_byte_serializer #(.HOLD_CYCLES(H), .DEPTH(D)) dut0 (
      .clk(clk), .rst(rst), .result_in(d0), .result_valid(v0), .result_ready(ready0),
      .out(out0), .out_idx(idx0), .out_valid(valid0), .frame_start(fs0), .overflow(ovf0));

   result_byte_serializer #(.HOLD_CYCLES(1), .DEPTH(D)) dut1 (
      .clk(clk), .rst(rst), .result_in(d1), .result_valid(v1), .result_ready(ready1),
      .out(out1), .out_idx(idx1), .out_valid(valid1), .frame_start(fs1), .overflow(ovf1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_update(input bit r, input bit v, input logic [31:0] d);
      bit full, dup, do_pop;
      if (r) begin
         mq.delete();
         m_active = 0; m_k = 0; m_out = 8'h00; m_idx = 2'd0;
         m_fs = 0; m_ovf = 0; m_seen = 0;
         return;
      end
      full = (mq.size() == D);
`ifdef RESULT_CHANGE_ONLY_EN
      dup = m_seen && (d == m_last);
`else
      dup = 0;
`endif
      do_pop = (mq.size() > 0) && (!m_active || m_k == FL - 1);
      m_fs = 0;
      if (do_pop) begin
         m_word = mq.pop_front();
         m_k = 0; m_active = 1; m_fs = 1;
      end else if (m_active) begin
         if (m_k < FL - 1) m_k++;
         else m_active = 0;
      end
      if (m_active) begin
         m_idx = 2'(m_k / H);
         m_out = 8'(m_word >> (8 * (3 - m_k / H)));
      end
      if (v && !dup) begin
         if (full) m_ovf = 1;
         else begin
            mq.push_back(d);
            m_last = d;
            m_seen = 1;
         end
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [31:0] d);
      rst = r; v0 = v; d0 = d;
      @(posedge clk);
      model_update(r, v, d);
      #1;
      chk("out", {24'd0, out0}, {24'd0, m_out});
      chk("out_idx", {30'd0, idx0}, {30'd0, m_idx});
      chk("out_valid", {31'd0, valid0}, {31'd0, m_active});
      chk("frame_start", {31'd0, fs0}, {31'd0, m_fs});
      chk("overflow", {31'd0, ovf0}, {31'd0, m_ovf});
      chk("result_ready", {31'd0, ready0}, {31'd0, (mq.size() < D)});
      if (fs0) frames++;
      v1 = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 32'h0);
   endtask

   initial begin
      logic [7:0] h1_bytes [4];
      int p;
      rst = 1'b1; v0 = 1'b0; d0 = '0; v1 = 1'b0; d1 = '0;
      h1_bytes[0] = 8'hA5; h1_bytes[1] = 8'hA5; h1_bytes[2] = 8'h0F; h1_bytes[3] = 8'h0F;

      step(1, 0, 32'h0);
      step(1, 0, 32'h0);
      chk("reset_ready", {31'd0, ready0}, 32'd1);
      chk("reset_out", {24'd0, out0}, 32'd0);

      // Single frame, then out must keep the last byte.
      frames = 0;
      step(0, 1, 32'hDEADBEEF);
      idle(20);
      chk("single_frames", frames, 1);
      chk("single_last_byte", {24'd0, out0}, 32'h000000EF);

      // Two words back to back.
      frames = 0;
      step(0, 1, 32'h11223344);
      step(0, 1, 32'h55667788);
      idle(36);
      chk("pair_frames", frames, 2);

      // Six consecutive valid words into a four-entry FIFO.
      frames = 0;
      for (int i = 0; i < 6; i++) step(0, 1, 32'hA0000000 + i);
      chk("burst_overflow", {31'd0, ovf0}, 32'd1);
      idle(5 * FL + 4);
      chk("burst_frames", frames, 5);

      // Reset in the middle of byte 2.
      step(0, 1, 32'hCAFEF00D);
      idle(9);
      chk("pre_reset_idx", {30'd0, idx0}, 32'd2);
      step(1, 0, 32'h0);
      chk("mid_rst_out", {24'd0, out0}, 32'd0);
      chk("mid_rst_valid", {31'd0, valid0}, 32'd0);
      chk("mid_rst_idx", {30'd0, idx0}, 32'd0);
      chk("mid_rst_ovf", {31'd0, ovf0}, 32'd0);
      chk("mid_rst_ready", {31'd0, ready0}, 32'd1);
      frames = 0;
      idle(10);
      chk("post_rst_frames", frames, 0);

      // HOLD_CYCLES=1 instance.
      v1 = 1'b1; d1 = 32'hA5A50F0F;
      step(0, 0, 32'h0);
      chk("h1_idle_valid", {31'd0, valid1}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 32'h0);
         chk("h1_out", {24'd0, out1}, {24'd0, h1_bytes[i]});
         chk("h1_idx", {30'd0, idx1}, i);
         chk("h1_valid", {31'd0, valid1}, 32'd1);
         chk("h1_fs", {31'd0, fs1}, (i == 0) ? 32'd1 : 32'd0);
      end
      step(0, 0, 32'h0);
      chk("h1_end_valid", {31'd0, valid1}, 32'd0);
      chk("h1_end_out", {24'd0, out1}, 32'h0000000F);
      chk("h1_end_idx", {30'd0, idx1}, 32'd3);
      chk("h1_ready", {31'd0, ready1}, 32'd1);
      chk("h1_ovf", {31'd0, ovf1}, 32'd0);

      // Same word twice with a two-cycle gap.
      frames = 0;
      step(0, 1, 32'h12345678);
      idle(2);
      step(0, 1, 32'h12345678);
      idle(40);
`ifdef RESULT_CHANGE_ONLY_EN
      chk("repeat_frames", frames, 1);
`else
      chk("repeat_frames", frames, 2);
`endif

      // Randomized traffic with a small word pool to create repeats and bursts.
      for (int i = 0; i < 500; i++) begin
         logic [31:0] w;
         p = (i < 250) ? 1 : 6;
         w = ($urandom_range(0, 3) == 0) ? $urandom : (32'h5A000000 + $urandom_range(0, 3));
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, p) == 0), w);
      end
      idle(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
